// File: rtl/tilemap_fetch_sequencer.sv
// Tile-layer VRAM fetch sequencer: beam counters, double-buffered scroll registers,
// per-slot name/attr fetch addresses for layers A and B. Optional FLIP_SCREEN_EN adds FLIP_I.
module tilemap_fetch_sequencer #(
  parameter int unsigned H_TOTAL   = 384,
  parameter int unsigned V_TOTAL   = 264,
  parameter int unsigned CPU_SLOTS = 4
) (
  input  logic        CLK_6M_I,
  input  logic        RST_I,
  input  logic        HRESET_I,
  input  logic        VRESET_I,
  input  logic        VBLANK_I,
`ifdef FLIP_SCREEN_EN
  input  logic        FLIP_I,
`endif
  input  logic        CPU_WE_I,
  input  logic [2:0]  CPU_ADDR_I,
  input  logic [7:0]  CPU_DATA_I,
  output logic [12:0] VRAM_ADDR_O,
  output logic        FETCH_EN_O,
  output logic        LAYER_O,
  output logic        CPU_WIN_O,
  output logic [2:0]  FINE_X_A_O,
  output logic [2:0]  FINE_X_B_O,
  output logic [2:0]  FINE_Y_A_O,
  output logic [2:0]  FINE_Y_B_O,
  output logic [8:0]  HCOUNT_O,
  output logic [8:0]  VCOUNT_O
);

  localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
  localparam logic [3:0] FETCH_SLOTS = 4'(8 - CPU_SLOTS);

  logic [8:0] hcount, vcount;
  logic       h_wrap;

  logic [8:0] pend_ax, pend_bx, act_ax, act_bx;
  logic [7:0] pend_ay, pend_by, act_ay, act_by;
  logic       flip_q;

  logic [2:0] phase;
  logic       fetch_phase;
  logic       layer_sel;
  logic [8:0] h_ahead, h_eff, sel_x, ex;
  logic [7:0] v_eff, sel_y, ey, ey_a, ey_b;
  logic [2:0] fine_x_a, fine_x_b;

  assign h_wrap = (hcount == H_LAST);

  always_ff @(posedge CLK_6M_I) begin
    if (RST_I) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      if (HRESET_I || h_wrap) hcount <= '0;
      else                    hcount <= hcount + 9'd1;

      if (VRESET_I)                 vcount <= '0;
      else if (HRESET_I || h_wrap)  vcount <= (vcount == V_LAST) ? '0 : vcount + 9'd1;
    end
  end

  // Pending copy is CPU-visible; the active copy only moves at frame start, so a
  // write coinciding with VRESET_I lands in pending and waits a full frame.
  always_ff @(posedge CLK_6M_I) begin
    if (RST_I) begin
      pend_ax <= '0;
      pend_ay <= '0;
      pend_bx <= '0;
      pend_by <= '0;
      act_ax  <= '0;
      act_ay  <= '0;
      act_bx  <= '0;
      act_by  <= '0;
      flip_q  <= 1'b0;
    end else begin
      if (VRESET_I) begin
        act_ax <= pend_ax;
        act_ay <= pend_ay;
        act_bx <= pend_bx;
        act_by <= pend_by;
`ifdef FLIP_SCREEN_EN
        flip_q <= FLIP_I;
`else
        flip_q <= 1'b0;
`endif
      end
      if (CPU_WE_I) begin
        case (CPU_ADDR_I)
          3'd0:    pend_ax[7:0] <= CPU_DATA_I;
          3'd1:    pend_ax[8]   <= CPU_DATA_I[0];
          3'd2:    pend_ay      <= CPU_DATA_I;
          3'd4:    pend_bx[7:0] <= CPU_DATA_I;
          3'd5:    pend_bx[8]   <= CPU_DATA_I[0];
          3'd6:    pend_by      <= CPU_DATA_I;
          default: ;
        endcase
      end
    end
  end

  assign phase       = hcount[2:0];
  assign fetch_phase = ({1'b0, phase} < FETCH_SLOTS);
  assign layer_sel   = phase[1];
  assign h_ahead     = hcount + 9'd8;

  always_comb begin
    h_eff    = h_ahead;
    v_eff    = vcount[7:0];
    fine_x_a = act_ax[2:0];
    fine_x_b = act_bx[2:0];
    if (flip_q) begin
      h_eff    = ~h_ahead;
      v_eff    = ~vcount[7:0];
      fine_x_a = ~act_ax[2:0];
      fine_x_b = ~act_bx[2:0];
    end
  end

  assign sel_x = layer_sel ? act_bx : act_ax;
  assign sel_y = layer_sel ? act_by : act_ay;
  assign ex    = h_eff + sel_x;
  assign ey    = v_eff + sel_y;
  assign ey_a  = v_eff + act_ay;
  assign ey_b  = v_eff + act_by;

  // Address and layer only move on fetch slots; CPU slots and VBLANK hold them.
  always_ff @(posedge CLK_6M_I) begin
    if (RST_I) begin
      VRAM_ADDR_O <= '0;
      FETCH_EN_O  <= 1'b0;
      LAYER_O     <= 1'b0;
      CPU_WIN_O   <= 1'b1;
      FINE_X_A_O  <= '0;
      FINE_X_B_O  <= '0;
      FINE_Y_A_O  <= '0;
      FINE_Y_B_O  <= '0;
    end else begin
      FINE_X_A_O <= fine_x_a;
      FINE_X_B_O <= fine_x_b;
      FINE_Y_A_O <= ey_a[2:0];
      FINE_Y_B_O <= ey_b[2:0];
      if (!VBLANK_I && fetch_phase) begin
        FETCH_EN_O  <= 1'b1;
        CPU_WIN_O   <= 1'b0;
        LAYER_O     <= layer_sel;
        VRAM_ADDR_O <= {layer_sel, ey[7:3], ex[8:3], phase[0]};
      end else begin
        FETCH_EN_O <= 1'b0;
        CPU_WIN_O  <= 1'b1;
      end
    end
  end

  assign HCOUNT_O = hcount;
  assign VCOUNT_O = vcount;

endmodule

// File: tb/tb_tilemap_fetch_sequencer.sv
// Self-checking bench for tilemap_fetch_sequencer: directed scenarios plus random
// stimulus against an arithmetic reference model of beam position and scroll state.
module tb_tilemap_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, hres, vres, vblank, we;
  logic [2:0]  addr;
  logic [7:0]  data;
  logic [12:0] vram_addr;
  logic        fetch_en, layer, cpu_win;
  logic [2:0]  fxa, fxb, fya, fyb;
  logic [8:0]  hcnt, vcnt;

  always #5 clk = ~clk;

  tilemap_fetch_sequencer #(.H_TOTAL(384), .V_TOTAL(264), .CPU_SLOTS(4)) dut (
    .CLK_6M_I   (clk),
    .RST_I      (rst),
    .HRESET_I   (hres),
    .VRESET_I   (vres),
    .VBLANK_I   (vblank),
`ifdef FLIP_SCREEN_EN
    .FLIP_I     (1'b0),
`endif
    .CPU_WE_I   (we),
    .CPU_ADDR_I (addr),
    .CPU_DATA_I (data),
    .VRAM_ADDR_O(vram_addr),
    .FETCH_EN_O (fetch_en),
    .LAYER_O    (layer),
    .CPU_WIN_O  (cpu_win),
    .FINE_X_A_O (fxa),
    .FINE_X_B_O (fxb),
    .FINE_Y_A_O (fya),
    .FINE_Y_B_O (fyb),
    .HCOUNT_O   (hcnt),
    .VCOUNT_O   (vcnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: beam position and scroll values as plain integers.
  int unsigned m_h, m_v;
  int unsigned pax, pay, pbx, pby, aax, aay, abx, aby;
  int unsigned e_addr, e_fe, e_layer, e_cpu, e_fxa, e_fxb, e_fya, e_fyb;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int unsigned p, lsel, lx, ly, ex, ey;
    bit wrapped;
    if (rst) begin
      e_addr = 0; e_fe = 0; e_layer = 0; e_cpu = 1;
      e_fxa = 0; e_fxb = 0; e_fya = 0; e_fyb = 0;
    end else begin
      p     = m_h % 8;
      e_fxa = aax % 8;
      e_fxb = abx % 8;
      e_fya = ((m_v % 256 + aay) % 256) % 8;
      e_fyb = ((m_v % 256 + aby) % 256) % 8;
      if (!vblank && p < 4) begin
        lsel    = p / 2;
        lx      = (lsel == 1) ? abx : aax;
        ly      = (lsel == 1) ? aby : aay;
        ex      = (m_h + 8 + lx) % 512;
        ey      = (m_v % 256 + ly) % 256;
        e_addr  = lsel * 4096 + (ey / 8) * 128 + (ex / 8) * 2 + p % 2;
        e_layer = lsel;
        e_fe    = 1;
        e_cpu   = 0;
      end else begin
        e_fe  = 0;
        e_cpu = 1;
      end
    end

    if (rst) begin
      m_h = 0; m_v = 0;
      pax = 0; pay = 0; pbx = 0; pby = 0;
      aax = 0; aay = 0; abx = 0; aby = 0;
    end else begin
      wrapped = (m_h == 383);
      if (vres) m_v = 0;
      else if (hres || wrapped) m_v = (m_v + 1) % 264;
      m_h = (hres || wrapped) ? 0 : m_h + 1;
      if (vres) begin
        aax = pax; aay = pay; abx = pbx; aby = pby;
      end
      if (we) begin
        case (addr)
          3'd0: pax = (pax / 256) * 256 + data;
          3'd1: pax = (pax % 256) + (data % 2) * 256;
          3'd2: pay = data;
          3'd4: pbx = (pbx / 256) * 256 + data;
          3'd5: pbx = (pbx % 256) + (data % 2) * 256;
          3'd6: pby = data;
          default: ;
        endcase
      end
    end

    @(posedge clk);
    #1;
    chk("hcount",    16'(hcnt),      16'(m_h));
    chk("vcount",    16'(vcnt),      16'(m_v));
    chk("vram_addr", 16'(vram_addr), 16'(e_addr));
    chk("fetch_en",  16'(fetch_en),  16'(e_fe));
    chk("layer",     16'(layer),     16'(e_layer));
    chk("cpu_win",   16'(cpu_win),   16'(e_cpu));
    chk("fine_x_a",  16'(fxa),       16'(e_fxa));
    chk("fine_x_b",  16'(fxb),       16'(e_fxb));
    chk("fine_y_a",  16'(fya),       16'(e_fya));
    chk("fine_y_b",  16'(fyb),       16'(e_fyb));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; data = d;
    step();
    we = 1'b0;
  endtask

  task automatic frame_pulse();
    hres = 1'b1; vres = 1'b1;
    step();
    hres = 1'b0; vres = 1'b0;
  endtask

  task automatic short_line(input int unsigned n);
    for (int unsigned i = 1; i < n; i++) step();
    hres = 1'b1;
    step();
    hres = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hres = 1'b0; vres = 1'b0; vblank = 1'b0;
    we = 1'b0; addr = '0; data = '0;
    e_addr = 0; e_layer = 0;
    m_h = 0; m_v = 0;
    step();
    step();
    chk("reset_cpu_win", 16'(cpu_win), 16'h1);
    chk("reset_addr",    16'(vram_addr), 16'h0);
    rst = 1'b0;

    // Scroll all zero: first fetch of the line targets column 1.
    frame_pulse();
    step();
    chk("tp_a_name_p0", 16'(vram_addr), 16'h0002);
    chk("tp_fetch_en_p0", 16'(fetch_en), 16'h1);
    step(); step(); step();
    chk("tp_b_attr_p3", 16'(vram_addr), 16'h1003);
    chk("tp_layer_p3",  16'(layer),     16'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tp_cpu_slot_win", 16'(cpu_win),  16'h1);
      chk("tp_cpu_slot_fe",  16'(fetch_en), 16'h0);
    end

    // A_X = 0x1F8 cancels the one-tile look-ahead.
    wr(3'd0, 8'hF8);
    wr(3'd1, 8'h01);
    frame_pulse();
    step();
    chk("tp_ax_wrap_addr", 16'(vram_addr), 16'h0000);
    chk("tp_ax_fine_x",    16'(fxa),       16'h0);

    // A_Y written mid-frame only takes effect after the next frame start.
    while (m_v != 10) short_line(8);
    wr(3'd2, 8'hFC);
    short_line(8);
    frame_pulse();
    while (m_v != 4) short_line(8);
    step();
    chk("tp_ay_row0_addr", 16'(vram_addr), 16'h0000);
    chk("tp_ay_fine_y",    16'(fya),       16'h0);

    // B_X written in the VRESET cycle waits one more frame.
    we = 1'b1; addr = 3'd4; data = 8'h10;
    frame_pulse();
    we = 1'b0;
    step(); step(); step();
    chk("tp_bx_old_frame", 16'(vram_addr), 16'h1002);
    frame_pulse();
    step(); step(); step();
    chk("tp_bx_new_frame", 16'(vram_addr), 16'h1006);

    // Three full lines of VBLANK with natural horizontal wrap.
    vblank = 1'b1;
    for (int i = 0; i < 3 * 384; i++) begin
      step();
      chk("vblank_fe",  16'(fetch_en), 16'h0);
      chk("vblank_win", 16'(cpu_win),  16'h1);
    end
    vblank = 1'b0;
    for (int i = 0; i < 400; i++) step();

    // Run the vertical counter through its wrap using short lines.
    for (int i = 0; i < 270; i++) short_line(4);

    // Random stimulus with mid-line resets, early line/frame starts and CPU writes.
    for (int i = 0; i < 6000; i++) begin
      rst    = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) vblank = ~vblank;
      we     = ($urandom_range(0, 7) == 0);
      addr   = 3'($urandom_range(0, 7));
      data   = 8'($urandom);
      hres   = (m_h == 383) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
      vres   = hres && ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; hres = 1'b0; vres = 1'b0; we = 1'b0; vblank = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
